seconds_counter: RTL and testbench

- Modulo-60 seconds counter for the clock/timer datapath.
- Advances once per enabled count event, holds its value while disabled, and wraps 59 -> 0.
- On each wrap it emits a one-cycle tick_minute pulse that drives the downstream minutes counter's enable.

---
 rtl/seconds_counter.sv | 101 ++++++++++
 tb/tb_seconds_counter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seconds_counter.sv
// -----------------------------------------------------------------------------
// seconds_counter
//
// Modulo-(MAX_COUNT+1) seconds counter for the clock/timer datapath.
// The counter advances once per count event and holds while enable is low.
// After MAX_COUNT it wraps to 0 and raises tick_minute for exactly one clock.
// That pulse feeds the minutes counter's enable.
//
// Optional feature (compile-time macro SECONDS_PRESCALE_EN):
//   When the macro is defined, a prescaler counts enabled clocks. Only every
//   CLKS_PER_SEC-th enabled clock becomes a count event. When the macro is
//   undefined, every enabled clock is a count event and CLKS_PER_SEC is
//   ignored.
//
// Parameters:
//   MAX_COUNT    terminal count; the counter wraps to 0 after this value
//   WIDTH        width of seconds; 2**WIDTH must exceed MAX_COUNT
//   CLKS_PER_SEC enabled clocks per count event (prescaler build only)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous reset, ACTIVE-HIGH (1 = reset). The name is
//                historical and matches the rest of the codebase.
//   enable       level-sensitive count enable
//   seconds      registered count, 0..MAX_COUNT
//   tick_minute  registered one-cycle pulse, high in the cycle where seconds
//                first reads 0 after a wrap
// -----------------------------------------------------------------------------
module seconds_counter #(
  parameter int MAX_COUNT    = 59,
  parameter int WIDTH        = 6,
  parameter int CLKS_PER_SEC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic [WIDTH-1:0] seconds,
  output logic             tick_minute
);

  localparam logic [WIDTH-1:0] TERMINAL = WIDTH'(MAX_COUNT);

  // Elaboration-time sanity checks on the parameter set.
  if ((64'd1 << WIDTH) <= 64'(MAX_COUNT)) begin : g_bad_width
    $error("seconds_counter: WIDTH too small to hold MAX_COUNT");
  end
  if (CLKS_PER_SEC < 1) begin : g_bad_prescale
    $error("seconds_counter: CLKS_PER_SEC must be at least 1");
  end

  logic count_event;

`ifdef SECONDS_PRESCALE_EN
  localparam int PS_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLKS_PER_SEC - 1);

  logic [PS_W-1:0] prescale;

  // The terminal test uses >= so that an unreachable out-of-range value still
  // recovers on the next enabled clock.
  assign count_event = enable && (prescale >= PS_LAST);

  // NOTE: sequential state is written with non-blocking assignments only.
  // Every flop then samples the pre-edge values, with no dependence on
  // process ordering.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      prescale <= '0;
    end else if (enable) begin
      if (prescale >= PS_LAST) prescale <= '0;
      else                     prescale <= prescale + PS_W'(1);
    end
  end
`else
  assign count_event = enable;
`endif

  // Reset has priority over counting. Any edge that is not a count event
  // clears tick_minute, so the pulse can never stretch past one cycle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      seconds     <= '0;
      tick_minute <= 1'b0;
    end else if (count_event) begin
      if (seconds == TERMINAL) begin
        seconds     <= '0;
        tick_minute <= 1'b1;
      end else if (seconds > TERMINAL) begin
        // Out-of-range recovery: reload 0 and do not raise a tick.
        seconds     <= '0;
        tick_minute <= 1'b0;
      end else begin
        seconds     <= seconds + WIDTH'(1);
        tick_minute <= 1'b0;
      end
    end else begin
      tick_minute <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seconds_counter.sv
// -----------------------------------------------------------------------------
// tb_seconds_counter
//
// Scoreboard bench for seconds_counter.
// The stimulus side drives inputs on the falling edge. It updates a
// behavioural model: the count of events since reset, reduced modulo 60.
// It then pushes the expected post-edge outputs into a queue.
// A separate monitor pops one entry after every rising edge and compares.
// Define SECONDS_PRESCALE_EN to exercise the prescaler with CLKS_PER_SEC=4.
// -----------------------------------------------------------------------------
module tb_seconds_counter;

  localparam int MAX_COUNT = 59;
  localparam int WIDTH     = 6;
`ifdef SECONDS_PRESCALE_EN
  localparam int CPS = 4;
`else
  localparam int CPS = 1;
`endif

  typedef struct {
    int unsigned secs;
    bit          tick;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic [WIDTH-1:0] seconds;
  logic             tick_minute;

  seconds_counter #(
    .MAX_COUNT   (MAX_COUNT),
    .WIDTH       (WIDTH),
    .CLKS_PER_SEC(CPS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .seconds    (seconds),
    .tick_minute(tick_minute)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  // Reference model state. Events are counted since the last reset, and the
  // expected display is derived from that count arithmetically.
  int unsigned m_events   = 0;
  int unsigned m_ps       = 0;
  bit          count_tick = 1'b0;
  int unsigned dut_ticks  = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Apply one clock of stimulus and queue the expected response.
  task automatic step(input logic rst, input logic en);
    exp_t e;
    bit   wrap;
    @(negedge clk);
    rst_n  = rst;
    enable = en;
    wrap   = 1'b0;
    if (rst) begin
      m_events = 0;
      m_ps     = 0;
    end else if (en) begin
      if (m_ps == CPS - 1) begin
        m_ps = 0;
        m_events++;
        wrap = (m_events % (MAX_COUNT + 1)) == 0;
      end else begin
        m_ps++;
      end
    end
    e.secs = m_events % (MAX_COUNT + 1);
    e.tick = wrap;
    sb_q.push_back(e);
  endtask

  task automatic run(input logic en, input int n);
    for (int i = 0; i < n; i++) step(1'b0, en);
  endtask

  // Sample the outputs just after a rising edge.
  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected entry per rising edge once stimulus has started.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_seconds", 32'(seconds), 32'(e.secs));
        check("sb_tick", 32'(tick_minute), 32'(e.tick));
        if (count_tick && tick_minute === 1'b1) dut_ticks++;
      end
    end
  end

  initial begin : stimulus
    int on_len;
    int off_len;
    rst_n  = 1'b1;
    enable = 1'b0;

    // Reset, then hold with enable low.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    run(1'b0, 5);

    // Free run across one wrap.
    step(1'b1, 1'b0);
    run(1'b1, 60 * CPS);
    sample();
    check("free_run_wrap_secs", 32'(seconds), 32'd0);
    check("free_run_wrap_tick", 32'(tick_minute), 32'd1);
    run(1'b1, CPS);
    sample();
    check("free_run_after_tick", 32'(tick_minute), 32'd0);

    // Pause and resume.
    step(1'b1, 1'b0);
    run(1'b1, 7 * CPS);
    run(1'b0, 10);
    sample();
    check("pause_hold", 32'(seconds), 32'd7);
    run(1'b1, 3 * CPS);
    sample();
    check("resume_value", 32'(seconds), 32'd10);

    // Pause at the terminal count, then wrap on a single event.
    step(1'b1, 1'b0);
    run(1'b1, 59 * CPS);
    run(1'b0, 5);
    sample();
    check("hold_at_59", 32'(seconds), 32'd59);
    run(1'b1, CPS);
    run(1'b0, 3);

    // Reset mid-count while enable is high, then resume counting.
    step(1'b1, 1'b0);
    run(1'b1, 42 * CPS);
    step(1'b1, 1'b1);
    sample();
    check("mid_reset_secs", 32'(seconds), 32'd0);
    run(1'b1, 2 * CPS);

`ifdef SECONDS_PRESCALE_EN
    // Eight enabled clocks at four clocks per event give two events.
    step(1'b1, 1'b0);
    run(1'b1, 8);
    sample();
    check("prescale_8clk", 32'(seconds), 32'd2);
`endif

    // Random enable bursts from reset, with tick accounting.
    step(1'b1, 1'b0);
    count_tick = 1'b1;
    for (int b = 0; b < 12; b++) begin
      on_len  = 1 + int'($urandom_range(40 * CPS));
      off_len = int'($urandom_range(15));
      run(1'b1, on_len);
      run(1'b0, off_len);
    end
    sample();
    count_tick = 1'b0;
    check("tick_count", 32'(dut_ticks), 32'(m_events / (MAX_COUNT + 1)));

    // Let the monitor drain, with a bounded wait.
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
